mem_cache_stage: RTL and testbench
==================================

MEM_CACHE_STAGE -- requirements
Module: mem_cache_stage

Interface
REQ-001: Parameter LINES, default 16, number of direct-mapped one-word cache lines (power of two).
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: MemRead  input  1  load request from EX/MEM stage.
REQ-005: MemWrite  input  1  store request from EX/MEM stage.
REQ-006: ALUResult  input  32  byte address; word-aligned, bits [1:0] ignored.
REQ-007: writeData  input  32  store data.
REQ-008: hit  output  1  load data valid this cycle; feeds MEM/WB hit.
REQ-009: readData  output  32  load data; feeds MEM/WB readData.
REQ-010: stall  output  1  freeze the upstream pipeline and hold inputs.
REQ-011: mem_req, mem_we  output  1 each  main-memory request and write-enable.
REQ-012: mem_addr, mem_wdata  output  32 each  main-memory word address ({ALUResult[31:2],2'b00}) and store data.
REQ-013: mem_ready  input  1  main-memory completion, one-cycle pulse; mem_rdata  input  32  read data, valid with mem_ready.
REQ-014: hit_count, miss_count  output  16 each  saturating statistics counters.

Function
REQ-015: Index = ALUResult[log2(LINES)+1:2]; tag = remaining upper bits; each line holds valid, tag, 32-bit data.
REQ-016: FSM states: IDLE, READ, WRITE, DONE.
REQ-017: IDLE, MemRead and MemWrite both 0: hit=0, stall=0, readData=0, no memory request.
REQ-018: IDLE, MemRead=1, MemWrite=0, valid and tag match: hit=1, readData=line data combinationally, stall=0, hit_count+1; stay IDLE.
REQ-019: IDLE, read miss: stall=1 combinationally same cycle, miss_count+1, next state READ.
REQ-020: IDLE, MemWrite=1 (MemWrite overrides MemRead): stall=1, hit=0; if valid and tag match, line data updated with writeData at the clock edge; no allocate on miss; next state WRITE.
REQ-021: READ: mem_req=1, mem_we=0, stall=1, hit=0; on mem_ready, line written (valid=1, tag, mem_rdata); next state DONE.
REQ-022: WRITE: mem_req=1, mem_we=1, mem_wdata=writeData, stall=1; on mem_ready, next state DONE.
REQ-023: mem_addr/mem_wdata stay stable while mem_req=1; mem_req deasserts the cycle after mem_ready.
REQ-024: DONE: stall=0; after a read, hit=1 and readData=refilled data; after a write, hit=0; counters unchanged; next state IDLE.
REQ-025: Upstream holds MemRead, MemWrite, ALUResult, writeData constant while stall=1; the block does not register them.
REQ-026: Counters saturate at 16'hFFFF and do not wrap.
REQ-027: mem_ready outside READ/WRITE is ignored.

Reset
REQ-028: rst_n=0 immediately forces state IDLE, all valid bits 0, counters 0, mem_req=0, mem_we=0, stall=0, hit=0, readData=0, regardless of clk.
REQ-029: Reset during READ/WRITE abandons the transaction; a later mem_ready is ignored; tag/data arrays need no reset.

Verification
REQ-030: Reset, read 0x40 -> stall=1 and mem_req=1, mem_addr=0x40 the following cycle; mem_ready with mem_rdata=0xDEADBEEF after 3 cycles -> next cycle DONE: hit=1, readData=0xDEADBEEF, stall=0; miss_count=1, hit_count=0.
REQ-031: Read 0x40 again -> hit=1, readData=0xDEADBEEF same cycle, no mem_req, hit_count=1.
REQ-032: Read 0x80 (same index 0) -> miss, refill 0x12345678; then read 0x40 -> miss again; miss_count=3.
REQ-033: Write 0x40 data 0x5 with line valid -> mem_we=1, mem_wdata=0x5 until mem_ready, DONE hit=0; read 0x40 -> hit=1, readData=0x5.
REQ-034: Read miss, assert rst_n=0 mid-READ -> mem_req=0 without clock edge; release, pulse mem_ready -> ignored; read 0x40 -> miss.
REQ-035: Force hit_count to 0xFFFF via repeated hits -> further hit leaves 0xFFFF.

Source files
------------

// File: rtl/mem_cache_stage.sv
// mem_cache_stage: direct-mapped, one-word-per-line cache for the MEM pipeline
// stage. Load hits return data in the same cycle. Load misses stall and refill
// the line from main memory. Stores are write-through and write-no-allocate:
// a store updates the line only when it already holds that address.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   MemRead, MemWrite        load / store request (held by upstream while stall=1)
//   ALUResult, writeData     byte address (word aligned) and store data
//   hit, readData            load data valid / load data toward MEM/WB
//   stall                    freeze upstream pipeline
//   mem_req, mem_we          main-memory request / write enable
//   mem_addr, mem_wdata      main-memory word address / store data
//   mem_ready, mem_rdata     main-memory completion pulse / read data
//   hit_count, miss_count    saturating load hit / miss statistics
module mem_cache_stage #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] writeData,
  output logic        hit,
  output logic [31:0] readData,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic              was_read_q, was_read_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];
  logic [15:0]       hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              lookup_hit;
  logic              hit_inc, miss_inc;
  logic              line_wr, refill;
  logic [31:0]       line_wdata;

  assign idx        = ALUResult[IDX_W+1:2];
  assign tag        = ALUResult[31:IDX_W+2];
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

  // Upstream holds the address and data steady during a stall, so memory
  // address/data can be driven straight from the inputs.
  assign mem_addr   = ALUResult & 32'hFFFF_FFFC;
  assign mem_wdata  = writeData;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    was_read_d = was_read_q;
    hit        = 1'b0;
    readData   = 32'h0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    line_wr    = 1'b0;
    refill     = 1'b0;
    line_wdata = writeData;
    unique case (state_q)
      IDLE: begin
        if (MemWrite) begin
          // Store: update the line only on a hit (no allocate), then go
          // write through to memory.
          stall      = 1'b1;
          line_wr    = lookup_hit;
          was_read_d = 1'b0;
          state_d    = WRITE;
        end else if (MemRead) begin
          if (lookup_hit) begin
            hit      = 1'b1;
            readData = data_mem[idx];
            hit_inc  = 1'b1;
          end else begin
            stall      = 1'b1;
            miss_inc   = 1'b1;
            was_read_d = 1'b1;
            state_d    = READ;
          end
        end
      end
      READ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          line_wr    = 1'b1;
          refill     = 1'b1;
          line_wdata = mem_rdata;
          state_d    = DONE;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        // The refilled line is already in the array, and the index is still
        // held by upstream, so the load data is read back from the line.
        if (was_read_q) begin
          hit      = 1'b1;
          readData = data_mem[idx];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must quiet the outputs immediately, even while a load is
    // presented to the (now empty) cache.
    if (!rst_n) begin
      hit      = 1'b0;
      readData = 32'h0;
      stall    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      was_read_q <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= 16'h0;
      miss_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      was_read_q <= was_read_d;
      if (refill) valid_q[idx] <= 1'b1;
      if (hit_inc && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'h1;
      if (miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'h1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (line_wr && rst_n) data_mem[idx] <= line_wdata;
    if (refill && rst_n)  tag_mem[idx]  <= tag;
  end

endmodule

// File: tb/tb_mem_cache_stage.sv
// Directed testbench for mem_cache_stage. Inputs are driven on the falling
// edge and outputs sampled 1 ns later, away from the rising edge.
module tb_mem_cache_stage;

  logic        clk;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] ALUResult, writeData;
  logic        hit;
  logic [31:0] readData;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_cache_stage #(.LINES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .writeData  (writeData),
    .hit        (hit),
    .readData   (readData),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string nm, input logic [15:0] hc, input logic [15:0] mc);
    check({nm, "_hit_count"},  32'(hit_count),  32'(hc));
    check({nm, "_miss_count"}, 32'(miss_count), 32'(mc));
  endtask

  // Load that must miss: 3-cycle memory latency, then DONE returns the fill.
  task automatic read_miss(input string nm, input logic [31:0] addr, input logic [31:0] fill);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUResult = addr;
    #1;
    check({nm, "_idle_stall"}, 32'(stall), 32'd1);
    check({nm, "_idle_hit"},   32'(hit),   32'd0);
    @(negedge clk);
    check({nm, "_rd_req"},   32'(mem_req), 32'd1);
    check({nm, "_rd_we"},    32'(mem_we),  32'd0);
    check({nm, "_rd_addr"},  mem_addr,     addr & 32'hFFFF_FFFC);
    check({nm, "_rd_stall"}, 32'(stall),   32'd1);
    repeat (2) @(negedge clk);
    check({nm, "_rd_req_hold"},  32'(mem_req), 32'd1);
    check({nm, "_rd_addr_hold"}, mem_addr,     addr & 32'hFFFF_FFFC);
    mem_ready = 1'b1; mem_rdata = fill;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check({nm, "_done_hit"},   32'(hit),     32'd1);
    check({nm, "_done_data"},  readData,     fill);
    check({nm, "_done_stall"}, 32'(stall),   32'd0);
    check({nm, "_done_req"},   32'(mem_req), 32'd0);
    MemRead = 1'b0;
    $display("read  miss addr=0x%08h fill=0x%08h data=0x%08h", addr, fill, readData);
  endtask

  task automatic read_hit(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUResult = addr;
    #1;
    check({nm, "_hit"},   32'(hit),     32'd1);
    check({nm, "_data"},  readData,     exp);
    check({nm, "_stall"}, 32'(stall),   32'd0);
    check({nm, "_req"},   32'(mem_req), 32'd0);
    $display("read  hit  addr=0x%08h data=0x%08h", addr, readData);
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic write_op(input string nm, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b0; ALUResult = addr; writeData = data;
    #1;
    check({nm, "_idle_stall"}, 32'(stall), 32'd1);
    check({nm, "_idle_hit"},   32'(hit),   32'd0);
    @(negedge clk);
    check({nm, "_wr_req"},   32'(mem_req), 32'd1);
    check({nm, "_wr_we"},    32'(mem_we),  32'd1);
    check({nm, "_wr_wdata"}, mem_wdata,    data);
    check({nm, "_wr_addr"},  mem_addr,     addr & 32'hFFFF_FFFC);
    @(negedge clk);
    check({nm, "_wr_we_hold"},    32'(mem_we), 32'd1);
    check({nm, "_wr_wdata_hold"}, mem_wdata,   data);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check({nm, "_done_hit"},   32'(hit),     32'd0);
    check({nm, "_done_stall"}, 32'(stall),   32'd0);
    check({nm, "_done_req"},   32'(mem_req), 32'd0);
    MemWrite = 1'b0;
    $display("write      addr=0x%08h data=0x%08h", addr, data);
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ALUResult = 32'h0; writeData = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    check("rst_hit",   32'(hit),     32'd0);
    check("rst_stall", 32'(stall),   32'd0);
    check("rst_data",  readData,     32'h0);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we),  32'd0);
    check_counts("rst", 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // Cold miss, then hit on the same line.
    read_miss("r40_cold", 32'h40, 32'hDEADBEEF);
    check_counts("after_cold", 16'd0, 16'd1);
    read_hit("r40_hit", 32'h40, 32'hDEADBEEF);
    check_counts("after_hit", 16'd1, 16'd1);

    // Conflict on index 0: 0x80 evicts 0x40, which then misses again.
    read_miss("r80_conf", 32'h80, 32'h12345678);
    read_miss("r40_again", 32'h40, 32'hDEADBEEF);
    check_counts("after_conf", 16'd1, 16'd3);

    // Write hit updates the line; following load sees the new data.
    write_op("w40", 32'h40, 32'h5);
    read_hit("r40_after_w", 32'h40, 32'h5);
    check_counts("after_w", 16'd2, 16'd3);

    // Write miss does not allocate.
    write_op("w44", 32'h44, 32'hCAFE0001);
    read_miss("r44_noalloc", 32'h44, 32'h0BADF00D);
    check_counts("after_noalloc", 16'd2, 16'd4);

    // Stray mem_ready in IDLE is ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stray_ready_req",   32'(mem_req), 32'd0);
    check("stray_ready_stall", 32'(stall),   32'd0);
    $display("stray mem_ready in idle");
    read_hit("r40_post_stray", 32'h40, 32'h5);

    // Reset in the middle of a refill.
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h48;
    @(negedge clk);
    check("midrd_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req",   32'(mem_req), 32'd0);
    check("midrst_stall", 32'(stall),   32'd0);
    check("midrst_hit",   32'(hit),     32'd0);
    check("midrst_data",  readData,     32'h0);
    check_counts("midrst", 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("late_ready_req",   32'(mem_req), 32'd0);
    check("late_ready_stall", 32'(stall),   32'd0);
    $display("reset during refill, late mem_ready");
    read_miss("r40_after_rst", 32'h40, 32'hAAAA0000);
    check_counts("after_rst", 16'd0, 16'd1);

    // Hit counter saturation: hold a hitting load for 65534+ cycles.
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h40;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", 32'(hit_count), 32'h0000FFFE);
    @(negedge clk);
    check("sat_ffff", 32'(hit_count), 32'h0000FFFF);
    repeat (2) @(negedge clk);
    check("sat_hold", 32'(hit_count), 32'h0000FFFF);
    check("sat_hit",  32'(hit),       32'd1);
    check("sat_data", readData,       32'hAAAA0000);
    check("sat_miss", 32'(miss_count), 32'd1);
    MemRead = 1'b0;
    $display("hit counter saturated at 0x%04h", hit_count);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
